// File: rtl/vga_timing_if.sv
// ---------------------------------------------------------------------------
// vga_timing_if
// Bundle between the VGA timing generator and the pixel pipeline.
//   ce_i, mode_i          : pixel enable and requested timing set (consumer -> generator)
//   hsync_o, vsync_o      : sync outputs at the active mode's polarity
//   activevideo_o         : current pixel lies in the visible area
//   x_px_o, y_px_o        : visible-area coordinates (0 outside the visible area)
//   hc_o, vc_o            : raw horizontal / vertical counters
//   line_start_o          : one-clk strobe when hc_o becomes 0
//   frame_start_o         : one-clk strobe when (hc_o,vc_o) becomes (0,0)
//   mode_o                : timing set currently in force
// master = the generator, slave = the consumer.
// ---------------------------------------------------------------------------
interface vga_timing_if #(
    parameter int CW = 10
);
    logic          ce_i;
    logic          mode_i;
    logic          hsync_o;
    logic          vsync_o;
    logic          activevideo_o;
    logic [CW-1:0] x_px_o;
    logic [CW-1:0] y_px_o;
    logic [CW-1:0] hc_o;
    logic [CW-1:0] vc_o;
    logic          line_start_o;
    logic          frame_start_o;
    logic          mode_o;

    modport master (
        input  ce_i, mode_i,
        output hsync_o, vsync_o, activevideo_o, x_px_o, y_px_o,
               hc_o, vc_o, line_start_o, frame_start_o, mode_o
    );

    modport slave (
        output ce_i, mode_i,
        input  hsync_o, vsync_o, activevideo_o, x_px_o, y_px_o,
               hc_o, vc_o, line_start_o, frame_start_o, mode_o
    );
endinterface

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
// Dual-mode parametrised VGA timing generator. Each line/frame is laid out
// as front porch, sync, back porch, visible area. The timing set requested
// on mode_i is adopted only at the frame wrap (or at reset).
// Ports:
//   clk_i  : pixel-domain clock
//   rst_i  : synchronous reset, active-high, priority over ce_i
//   vif    : vga_timing_if master modport (ce/mode in, all timing outputs out)
// All outputs are flops decoded from the same next-counter value, so they
// all describe the same pixel (hc_o, vc_o).
// ---------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int CW         = 10,
    parameter int H_ACTIVE_0 = 640,
    parameter int H_FP_0     = 16,
    parameter int H_PULSE_0  = 96,
    parameter int H_BP_0     = 48,
    parameter int V_ACTIVE_0 = 480,
    parameter int V_FP_0     = 10,
    parameter int V_PULSE_0  = 2,
    parameter int V_BP_0     = 33,
    parameter int HS_POL_0   = 0,
    parameter int VS_POL_0   = 0,
    parameter int H_ACTIVE_1 = 640,
    parameter int H_FP_1     = 24,
    parameter int H_PULSE_1  = 40,
    parameter int H_BP_1     = 128,
    parameter int V_ACTIVE_1 = 480,
    parameter int V_FP_1     = 9,
    parameter int V_PULSE_1  = 3,
    parameter int V_BP_1     = 28,
    parameter int HS_POL_1   = 0,
    parameter int VS_POL_1   = 0
) (
    input  logic          clk_i,
    input  logic          rst_i,
    vga_timing_if.master  vif
);
    localparam int BLACK_H_0 = H_FP_0 + H_PULSE_0 + H_BP_0;
    localparam int H_TOTAL_0 = BLACK_H_0 + H_ACTIVE_0;
    localparam int BLACK_V_0 = V_FP_0 + V_PULSE_0 + V_BP_0;
    localparam int V_TOTAL_0 = BLACK_V_0 + V_ACTIVE_0;
    localparam int BLACK_H_1 = H_FP_1 + H_PULSE_1 + H_BP_1;
    localparam int H_TOTAL_1 = BLACK_H_1 + H_ACTIVE_1;
    localparam int BLACK_V_1 = V_FP_1 + V_PULSE_1 + V_BP_1;
    localparam int V_TOTAL_1 = BLACK_V_1 + V_ACTIVE_1;

    localparam logic [CW-1:0] ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] ONE  = CW'(1);

    // Counters must be able to hold total-1 for both timing sets.
    generate
        if ((H_TOTAL_0 > (2 ** CW)) || (V_TOTAL_0 > (2 ** CW)) ||
            (H_TOTAL_1 > (2 ** CW)) || (V_TOTAL_1 > (2 ** CW))) begin : g_bad_timing
            $error("vga_timing_gen: timing totals exceed 2**CW");
        end
    endgenerate

    // Select the mode-0 or mode-1 value of a timing constant, sized to CW.
    function automatic logic [CW-1:0] pick(input logic m, input int v0, input int v1);
        return m ? CW'(v1) : CW'(v0);
    endfunction

    logic [CW-1:0] hc_r, vc_r, x_r, y_r;
    logic          mode_r, hsync_r, vsync_r, active_r, ls_r, fs_r;

    logic [CW-1:0] h_last_s, v_last_s, hc_n_s, vc_n_s;
    logic          h_wrap_s, v_wrap_s, mode_n_s, ls_n_s, fs_n_s;

    logic [CW-1:0] black_h_s, black_v_s, hs_beg_s, hs_end_s, vs_beg_s, vs_end_s;
    logic [CW-1:0] x_n_s, y_n_s;
    logic          hs_pol_s, vs_pol_s, hsync_n_s, vsync_n_s, active_n_s;

    // Next counter/mode/strobe values; wrap limits come from the mode in force.
    always_comb begin
        h_last_s = pick(mode_r, H_TOTAL_0 - 1, H_TOTAL_1 - 1);
        v_last_s = pick(mode_r, V_TOTAL_0 - 1, V_TOTAL_1 - 1);
        // >= rather than == so a corrupted counter still recovers at the wrap.
        h_wrap_s = (hc_r >= h_last_s);
        v_wrap_s = (vc_r >= v_last_s);
        hc_n_s   = hc_r;
        vc_n_s   = vc_r;
        mode_n_s = mode_r;
        ls_n_s   = 1'b0;
        fs_n_s   = 1'b0;
        if (rst_i) begin
            hc_n_s   = ZERO;
            vc_n_s   = ZERO;
            mode_n_s = vif.mode_i;
        end else if (vif.ce_i) begin
            if (h_wrap_s) begin
                hc_n_s = ZERO;
                ls_n_s = 1'b1;
                if (v_wrap_s) begin
                    vc_n_s   = ZERO;
                    fs_n_s   = 1'b1;
                    mode_n_s = vif.mode_i;
                end else begin
                    vc_n_s = vc_r + ONE;
                end
            end else begin
                hc_n_s = hc_r + ONE;
            end
        end else begin
            hc_n_s = hc_r;
        end
    end

    // Decode sync/active/coordinates from the next counters under the next mode.
    always_comb begin
        black_h_s  = pick(mode_n_s, BLACK_H_0, BLACK_H_1);
        black_v_s  = pick(mode_n_s, BLACK_V_0, BLACK_V_1);
        hs_beg_s   = pick(mode_n_s, H_FP_0, H_FP_1);
        hs_end_s   = pick(mode_n_s, H_FP_0 + H_PULSE_0, H_FP_1 + H_PULSE_1);
        vs_beg_s   = pick(mode_n_s, V_FP_0, V_FP_1);
        vs_end_s   = pick(mode_n_s, V_FP_0 + V_PULSE_0, V_FP_1 + V_PULSE_1);
        hs_pol_s   = mode_n_s ? (HS_POL_1 != 0) : (HS_POL_0 != 0);
        vs_pol_s   = mode_n_s ? (VS_POL_1 != 0) : (VS_POL_0 != 0);
        hsync_n_s  = ((hc_n_s >= hs_beg_s) && (hc_n_s < hs_end_s)) ? hs_pol_s : ~hs_pol_s;
        vsync_n_s  = ((vc_n_s >= vs_beg_s) && (vc_n_s < vs_end_s)) ? vs_pol_s : ~vs_pol_s;
        active_n_s = (hc_n_s >= black_h_s) && (vc_n_s >= black_v_s);
        if (active_n_s) begin
            x_n_s = hc_n_s - black_h_s;
            y_n_s = vc_n_s - black_v_s;
        end else begin
            x_n_s = ZERO;
            y_n_s = ZERO;
        end
    end

    // Output and state registers; reset forces the blanked, sync-inactive state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hc_r     <= ZERO;
            vc_r     <= ZERO;
            x_r      <= ZERO;
            y_r      <= ZERO;
            mode_r   <= vif.mode_i;
            hsync_r  <= ~hs_pol_s;
            vsync_r  <= ~vs_pol_s;
            active_r <= 1'b0;
            ls_r     <= 1'b0;
            fs_r     <= 1'b0;
        end else begin
            hc_r     <= hc_n_s;
            vc_r     <= vc_n_s;
            x_r      <= x_n_s;
            y_r      <= y_n_s;
            mode_r   <= mode_n_s;
            hsync_r  <= hsync_n_s;
            vsync_r  <= vsync_n_s;
            active_r <= active_n_s;
            ls_r     <= ls_n_s;
            fs_r     <= fs_n_s;
        end
    end

    assign vif.hc_o          = hc_r;
    assign vif.vc_o          = vc_r;
    assign vif.x_px_o        = x_r;
    assign vif.y_px_o        = y_r;
    assign vif.mode_o        = mode_r;
    assign vif.hsync_o       = hsync_r;
    assign vif.vsync_o       = vsync_r;
    assign vif.activevideo_o = active_r;
    assign vif.line_start_o  = ls_r;
    assign vif.frame_start_o = fs_r;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen. Horizontal timing is the default for both
// modes; vertical timing is shortened so whole frames stay a few thousand
// clocks long:
//   mode 0: 800 clks/line, hsync low 16..111, active hc>=160;
//           11 lines, vsync low vc 2..3, active vc>=7
//   mode 1: 832 clks/line, hsync low 24..63, active hc>=192;
//           9 lines, vsync low vc 1..3, active vc>=6
// dut1 is the same build with HS_POL_0=VS_POL_0=1.
module tb_vga_timing_gen;
    localparam int CW = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ce  = 1'b1;
    logic mode = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    vga_timing_if #(.CW(CW)) vif0 ();
    vga_timing_if #(.CW(CW)) vif1 ();

    assign vif0.ce_i   = ce;
    assign vif0.mode_i = mode;
    assign vif1.ce_i   = ce;
    assign vif1.mode_i = mode;

    vga_timing_gen #(
        .CW(CW), .V_ACTIVE_0(4), .V_FP_0(2), .V_PULSE_0(2), .V_BP_0(3),
        .V_ACTIVE_1(3), .V_FP_1(1), .V_PULSE_1(3), .V_BP_1(2)
    ) dut0 (.clk_i(clk), .rst_i(rst), .vif(vif0));

    vga_timing_gen #(
        .CW(CW), .V_ACTIVE_0(4), .V_FP_0(2), .V_PULSE_0(2), .V_BP_0(3),
        .V_ACTIVE_1(3), .V_FP_1(1), .V_PULSE_1(3), .V_BP_1(2),
        .HS_POL_0(1), .VS_POL_0(1)
    ) dut1 (.clk_i(clk), .rst_i(rst), .vif(vif1));

    always #5 clk = ~clk;

    typedef struct {
        int   n;
        logic ce, mode;
        int   hc, vc;
        logic hs, vs, act;
        int   x, y;
        logic ls, fs, mo;
    } vec_t;

    vec_t vecs[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic add(input int n, input logic c, input logic m, input int hc, input int vc,
                       input logic hs, input logic vs, input logic act, input int x, input int y,
                       input logic ls, input logic fs, input logic mo);
        vec_t v;
        v.n = n; v.ce = c; v.mode = m; v.hc = hc; v.vc = vc;
        v.hs = hs; v.vs = vs; v.act = act; v.x = x; v.y = y;
        v.ls = ls; v.fs = fs; v.mo = mo;
        vecs.push_back(v);
    endtask

    task automatic wait_fs(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            tick();
            if (vif0.frame_start_o === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Counts over one frame, from just after a frame_start up to and including the next one.
    task automatic measure(output int clks, output int ls, output int hsl, output int vsl,
                           output int act, output logic ok);
        clks = 0; ls = 0; hsl = 0; vsl = 0; act = 0; ok = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            tick();
            clks++;
            if (vif0.line_start_o === 1'b1) ls++;
            if (vif0.hsync_o === 1'b0) hsl++;
            if (vif0.vsync_o === 1'b0) vsl++;
            if (vif0.activevideo_o === 1'b1) act++;
            if (vif0.frame_start_o === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        int   clks, ls, hsl, vsl, act;
        logic ok;

        //   n     ce    mode  hc   vc  hs    vs    act   x    y   ls    fs    mo
        add(1,    1'b1, 1'b0, 1,   0,  1'b1, 1'b1, 1'b0, 0,   0,  1'b0, 1'b0, 1'b0);
        add(15,   1'b1, 1'b0, 16,  0,  1'b0, 1'b1, 1'b0, 0,   0,  1'b0, 1'b0, 1'b0);
        add(95,   1'b1, 1'b0, 111, 0,  1'b0, 1'b1, 1'b0, 0,   0,  1'b0, 1'b0, 1'b0);
        add(1,    1'b1, 1'b0, 112, 0,  1'b1, 1'b1, 1'b0, 0,   0,  1'b0, 1'b0, 1'b0);
        add(687,  1'b1, 1'b0, 799, 0,  1'b1, 1'b1, 1'b0, 0,   0,  1'b0, 1'b0, 1'b0);
        add(1,    1'b1, 1'b0, 0,   1,  1'b1, 1'b1, 1'b0, 0,   0,  1'b1, 1'b0, 1'b0);
        add(1,    1'b1, 1'b0, 1,   1,  1'b1, 1'b1, 1'b0, 0,   0,  1'b0, 1'b0, 1'b0);
        add(799,  1'b1, 1'b0, 0,   2,  1'b1, 1'b0, 1'b0, 0,   0,  1'b1, 1'b0, 1'b0);
        add(800,  1'b1, 1'b0, 0,   3,  1'b1, 1'b0, 1'b0, 0,   0,  1'b1, 1'b0, 1'b0);
        add(800,  1'b1, 1'b0, 0,   4,  1'b1, 1'b1, 1'b0, 0,   0,  1'b1, 1'b0, 1'b0);
        add(2560, 1'b1, 1'b0, 160, 7,  1'b1, 1'b1, 1'b1, 0,   0,  1'b0, 1'b0, 1'b0);
        add(1,    1'b1, 1'b0, 161, 7,  1'b1, 1'b1, 1'b1, 1,   0,  1'b0, 1'b0, 1'b0);
        add(638,  1'b1, 1'b0, 799, 7,  1'b1, 1'b1, 1'b1, 639, 0,  1'b0, 1'b0, 1'b0);
        add(160,  1'b1, 1'b0, 159, 8,  1'b1, 1'b1, 1'b0, 0,   0,  1'b0, 1'b0, 1'b0);
        add(1,    1'b1, 1'b0, 160, 8,  1'b1, 1'b1, 1'b1, 0,   1,  1'b0, 1'b0, 1'b0);
        add(2239, 1'b1, 1'b0, 799, 10, 1'b1, 1'b1, 1'b1, 639, 3,  1'b0, 1'b0, 1'b0);
        add(1,    1'b1, 1'b0, 0,   0,  1'b1, 1'b1, 1'b0, 0,   0,  1'b1, 1'b1, 1'b0);
        add(1,    1'b1, 1'b0, 1,   0,  1'b1, 1'b1, 1'b0, 0,   0,  1'b0, 1'b0, 1'b0);
        add(1,    1'b0, 1'b0, 1,   0,  1'b1, 1'b1, 1'b0, 0,   0,  1'b0, 1'b0, 1'b0);
        add(3,    1'b0, 1'b0, 1,   0,  1'b1, 1'b1, 1'b0, 0,   0,  1'b0, 1'b0, 1'b0);
        // mode_i=1 requested mid-frame: mode 0 timing must hold until the wrap
        add(3999, 1'b1, 1'b1, 0,   5,  1'b1, 1'b1, 1'b0, 0,   0,  1'b1, 1'b0, 1'b0);
        add(16,   1'b1, 1'b1, 16,  5,  1'b0, 1'b1, 1'b0, 0,   0,  1'b0, 1'b0, 1'b0);
        add(4783, 1'b1, 1'b1, 799, 10, 1'b1, 1'b1, 1'b1, 639, 3,  1'b0, 1'b0, 1'b0);
        add(1,    1'b1, 1'b1, 0,   0,  1'b1, 1'b1, 1'b0, 0,   0,  1'b1, 1'b1, 1'b1);
        add(23,   1'b1, 1'b1, 23,  0,  1'b1, 1'b1, 1'b0, 0,   0,  1'b0, 1'b0, 1'b1);
        add(1,    1'b1, 1'b1, 24,  0,  1'b0, 1'b1, 1'b0, 0,   0,  1'b0, 1'b0, 1'b1);
        add(39,   1'b1, 1'b1, 63,  0,  1'b0, 1'b1, 1'b0, 0,   0,  1'b0, 1'b0, 1'b1);
        add(1,    1'b1, 1'b1, 64,  0,  1'b1, 1'b1, 1'b0, 0,   0,  1'b0, 1'b0, 1'b1);
        add(767,  1'b1, 1'b1, 831, 0,  1'b1, 1'b1, 1'b0, 0,   0,  1'b0, 1'b0, 1'b1);
        add(1,    1'b1, 1'b1, 0,   1,  1'b1, 1'b0, 1'b0, 0,   0,  1'b1, 1'b0, 1'b1);
        add(1664, 1'b1, 1'b1, 0,   3,  1'b1, 1'b0, 1'b0, 0,   0,  1'b1, 1'b0, 1'b1);
        add(832,  1'b1, 1'b1, 0,   4,  1'b1, 1'b1, 1'b0, 0,   0,  1'b1, 1'b0, 1'b1);
        add(1856, 1'b1, 1'b1, 192, 6,  1'b1, 1'b1, 1'b1, 0,   0,  1'b0, 1'b0, 1'b1);
        add(2303, 1'b1, 1'b1, 831, 8,  1'b1, 1'b1, 1'b1, 639, 2,  1'b0, 1'b0, 1'b1);
        add(1,    1'b1, 1'b1, 0,   0,  1'b1, 1'b1, 1'b0, 0,   0,  1'b1, 1'b1, 1'b1);
        add(1,    1'b1, 1'b0, 1,   0,  1'b1, 1'b1, 1'b0, 0,   0,  1'b0, 1'b0, 1'b1);
        add(829,  1'b1, 1'b0, 830, 0,  1'b1, 1'b1, 1'b0, 0,   0,  1'b0, 1'b0, 1'b1);
        // ce toggling across a line wrap
        add(1,    1'b1, 1'b0, 831, 0,  1'b1, 1'b1, 1'b0, 0,   0,  1'b0, 1'b0, 1'b1);
        add(1,    1'b0, 1'b0, 831, 0,  1'b1, 1'b1, 1'b0, 0,   0,  1'b0, 1'b0, 1'b1);
        add(1,    1'b1, 1'b0, 0,   1,  1'b1, 1'b0, 1'b0, 0,   0,  1'b1, 1'b0, 1'b1);
        add(1,    1'b0, 1'b0, 0,   1,  1'b1, 1'b0, 1'b0, 0,   0,  1'b0, 1'b0, 1'b1);
        add(1,    1'b1, 1'b0, 1,   1,  1'b1, 1'b0, 1'b0, 0,   0,  1'b0, 1'b0, 1'b1);

        // Reset for 3 clocks with mode_i=0
        rst = 1'b1; ce = 1'b1; mode = 1'b0;
        repeat (3) tick();
        chk("rst.hc", vif0.hc_o, 0);
        chk("rst.vc", vif0.vc_o, 0);
        chk("rst.hs", vif0.hsync_o, 1);
        chk("rst.vs", vif0.vsync_o, 1);
        chk("rst.act", vif0.activevideo_o, 0);
        chk("rst.x", vif0.x_px_o, 0);
        chk("rst.y", vif0.y_px_o, 0);
        chk("rst.mo", vif0.mode_o, 0);
        chk("rst.ls", vif0.line_start_o, 0);
        chk("rst.fs", vif0.frame_start_o, 0);
        chk("rst.pol_hs", vif1.hsync_o, 0);
        chk("rst.pol_vs", vif1.vsync_o, 0);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            ce   = vecs[i].ce;
            mode = vecs[i].mode;
            repeat (vecs[i].n) tick();
            chk($sformatf("v%0d.hc", i), vif0.hc_o, vecs[i].hc);
            chk($sformatf("v%0d.vc", i), vif0.vc_o, vecs[i].vc);
            chk($sformatf("v%0d.hs", i), vif0.hsync_o, vecs[i].hs);
            chk($sformatf("v%0d.vs", i), vif0.vsync_o, vecs[i].vs);
            chk($sformatf("v%0d.act", i), vif0.activevideo_o, vecs[i].act);
            chk($sformatf("v%0d.x", i), vif0.x_px_o, vecs[i].x);
            chk($sformatf("v%0d.y", i), vif0.y_px_o, vecs[i].y);
            chk($sformatf("v%0d.ls", i), vif0.line_start_o, vecs[i].ls);
            chk($sformatf("v%0d.fs", i), vif0.frame_start_o, vecs[i].fs);
            chk($sformatf("v%0d.mo", i), vif0.mode_o, vecs[i].mo);
        end

        // Whole-frame aggregates: mode 0 frame, then mode 1 frame
        ce = 1'b1; mode = 1'b0;
        wait_fs(ok);
        chk("wait_fs", ok, 1);
        chk("fs0.mo", vif0.mode_o, 0);
        mode = 1'b1;
        measure(clks, ls, hsl, vsl, act, ok);
        chk("m0.done", ok, 1);
        chk("m0.clks", clks, 8800);
        chk("m0.lines", ls, 11);
        chk("m0.hs_low", hsl, 1056);
        chk("m0.vs_low", vsl, 1600);
        chk("m0.active", act, 2560);
        chk("m0.mo_after", vif0.mode_o, 1);
        measure(clks, ls, hsl, vsl, act, ok);
        chk("m1.done", ok, 1);
        chk("m1.clks", clks, 7488);
        chk("m1.lines", ls, 9);
        chk("m1.hs_low", hsl, 360);
        chk("m1.vs_low", vsl, 2496);
        chk("m1.active", act, 1920);
        chk("m1.mo_after", vif0.mode_o, 1);

        // Reset mid-frame at (300,2) in mode 1, with mode_i=0
        mode = 1'b0;
        repeat (832 * 2 + 300) tick();
        chk("pre_rst.hc", vif0.hc_o, 300);
        chk("pre_rst.vc", vif0.vc_o, 2);
        chk("pre_rst.mo", vif0.mode_o, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst.hc", vif0.hc_o, 0);
        chk("mid_rst.vc", vif0.vc_o, 0);
        chk("mid_rst.fs", vif0.frame_start_o, 0);
        chk("mid_rst.ls", vif0.line_start_o, 0);
        chk("mid_rst.mo", vif0.mode_o, 0);
        chk("mid_rst.hs", vif0.hsync_o, 1);
        chk("mid_rst.vs", vif0.vsync_o, 1);
        chk("mid_rst.pol_hs", vif1.hsync_o, 0);
        chk("mid_rst.pol_vs", vif1.vsync_o, 0);
        tick();
        chk("post_rst.hc", vif0.hc_o, 1);
        chk("post_rst.vc", vif0.vc_o, 0);
        chk("post_rst.ls", vif0.line_start_o, 0);
        chk("post_rst.fs", vif0.frame_start_o, 0);

        // Active-high polarity build
        repeat (15) tick();
        chk("pol.hs16", vif1.hsync_o, 1);
        chk("nom.hs16", vif0.hsync_o, 0);
        repeat (95) tick();
        chk("pol.hs111", vif1.hsync_o, 1);
        tick();
        chk("pol.hs112", vif1.hsync_o, 0);
        repeat (800 * 2 - 112) tick();
        chk("pol.vc", vif1.vc_o, 2);
        chk("pol.vs2", vif1.vsync_o, 1);
        chk("nom.vs2", vif0.vsync_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
